// File: rtl/formula_n_sqrt_sum_fsm_if.sv
// rtl/formula_n_sqrt_sum_fsm_if.sv - argument, result and isqrt-bank signals of the root-sum block
interface formula_n_sqrt_sum_fsm_if #(
    parameter int N_ARGS  = 3,
    parameter int N_ISQRT = 2,
    parameter int X_W     = 32,
    parameter int RES_W   = 32
);
    logic                       arg_vld;
    logic                       arg_rdy;
    logic [N_ARGS*X_W-1:0]      args;
    logic                       res_vld;
    logic [RES_W-1:0]           res;
    logic [N_ISQRT-1:0]         isqrt_x_vld;
    logic [N_ISQRT*X_W-1:0]     isqrt_x;
    logic [N_ISQRT-1:0]         isqrt_y_vld;
    logic [N_ISQRT*X_W/2-1:0]   isqrt_y;

    modport master (
        output arg_vld, args, isqrt_y_vld, isqrt_y,
        input  arg_rdy, res_vld, res, isqrt_x_vld, isqrt_x
    );

    modport slave (
        input  arg_vld, args, isqrt_y_vld, isqrt_y,
        output arg_rdy, res_vld, res, isqrt_x_vld, isqrt_x
    );
endinterface

// File: rtl/formula_n_sqrt_sum_fsm.sv
// rtl/formula_n_sqrt_sum_fsm.sv - sum of integer square roots scheduled in rounds over an external isqrt bank
module formula_n_sqrt_sum_fsm #(
    parameter int N_ARGS  = 3,
    parameter int N_ISQRT = 2,
    parameter int X_W     = 32,
    parameter int RES_W   = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    formula_n_sqrt_sum_fsm_if.slave  bus
);
    localparam int N_RND = (N_ARGS + N_ISQRT - 1) / N_ISQRT;
    localparam int RND_W = (N_RND > 1) ? $clog2(N_RND) : 1;
    localparam int Y_W   = X_W / 2;
    localparam int PAD_W = N_RND * N_ISQRT * X_W;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t                 state_q, state_d;
    logic [N_ARGS*X_W-1:0]  args_q, args_d;
    logic [RES_W-1:0]       acc_q, acc_d;
    logic [RES_W-1:0]       res_q, res_d;
    logic [RND_W-1:0]       round_q, round_d;
    logic [N_ISQRT-1:0]     got_q, got_d;

    logic [PAD_W-1:0]       args_pad;
    logic [N_ISQRT*X_W-1:0] x_sel;
    logic [N_ISQRT-1:0]     mask;
    logic [N_ISQRT-1:0]     hit;
    logic [RES_W-1:0]       acc_sum;
    logic                   last_round;

    // Captured args are zero-padded to whole rounds so a partial last round selects cleanly.
    always_comb begin
        args_pad = '0;
        args_pad[N_ARGS*X_W-1:0] = args_q;
        x_sel = '0;
        mask  = '0;
        for (int r = 0; r < N_RND; r++) begin
            if (round_q == RND_W'(r)) begin
                x_sel = args_pad[r*N_ISQRT*X_W +: N_ISQRT*X_W];
                for (int j = 0; j < N_ISQRT; j++) begin
                    mask[j] = (r * N_ISQRT + j) < N_ARGS;
                end
            end
        end
    end

    assign last_round = (round_q == RND_W'(N_RND - 1));
    assign hit        = (state_q == S_WAIT) ? (bus.isqrt_y_vld & mask & ~got_q) : '0;

    always_comb begin
        acc_sum = acc_q;
        for (int j = 0; j < N_ISQRT; j++) begin
            if (hit[j]) begin
                acc_sum = acc_sum + RES_W'(bus.isqrt_y[j*Y_W +: Y_W]);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        args_d  = args_q;
        acc_d   = acc_q;
        res_d   = res_q;
        round_d = round_q;
        got_d   = got_q;
        case (state_q)
            S_IDLE: begin
                if (bus.arg_vld) begin
                    args_d  = bus.args;
                    acc_d   = '0;
                    round_d = '0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                got_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                acc_d = acc_sum;
                got_d = got_q | hit;
                if ((got_q | hit) == mask) begin
                    if (last_round) begin
                        // res is loaded on entry to DONE so it is already valid during the strobe.
                        res_d   = acc_sum;
                        state_d = S_DONE;
                    end else begin
                        round_d = round_q + RND_W'(1);
                        state_d = S_ISSUE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            args_q  <= '0;
            acc_q   <= '0;
            res_q   <= '0;
            round_q <= '0;
            got_q   <= '0;
        end else begin
            state_q <= state_d;
            args_q  <= args_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            round_q <= round_d;
            got_q   <= got_d;
        end
    end

    assign bus.arg_rdy     = (state_q == S_IDLE);
    assign bus.isqrt_x_vld = (state_q == S_ISSUE) ? mask : '0;
    assign bus.isqrt_x     = x_sel;
    assign bus.res_vld     = (state_q == S_DONE);
    assign bus.res         = res_q;
endmodule
